multi_digit_entry: RTL and testbench

MULTI_DIGIT_ENTRY -- requirements
Module: multi_digit_entry

---
 rtl/multi_digit_entry_if.sv | 36 +++
 rtl/multi_digit_entry.sv | 143 ++++++++++++++
 tb/tb_multi_digit_entry.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_digit_entry_if.sv
// Bundle of the digit-entry handshake and display signals.
//   slave  : used by multi_digit_entry (receives the entry controls, drives the display)
//   master : used by whatever drives the entry controls and reads the display
// Signals:
//   digit_changed, number_input, backspace, clear, disp_val, val_digits : controls toward the block
//   digits, digit_count, full, showing, overflow, invalid               : status from the block
interface multi_digit_entry_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic          digit_changed;
    logic [3:0]    number_input;
    logic          backspace;
    logic          clear;
    logic          disp_val;
    logic [DW-1:0] val_digits;

    logic [DW-1:0] digits;
    logic [CW-1:0] digit_count;
    logic          full;
    logic          showing;
    logic          overflow;
    logic          invalid;

    modport slave (
        input  digit_changed, number_input, backspace, clear, disp_val, val_digits,
        output digits, digit_count, full, showing, overflow, invalid
    );

    modport master (
        output digit_changed, number_input, backspace, clear, disp_val, val_digits,
        input  digits, digit_count, full, showing, overflow, invalid
    );
endinterface

// File: rtl/multi_digit_entry.sv
// Keypad-style multi-digit entry register with backspace, clear and a
// value-display override.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : multi_digit_entry_if.slave
//          digit_changed / backspace are level inputs whose rising edges act;
//          clear and disp_val act while high; digits slot 0 is the newest digit.
// Parameters:
//   NUM_DIGITS : number of 4-bit slots (2..8)
//   BLANK_CODE : code shown in an unlit slot
//   OVF_MODE   : 0 = shift out the oldest digit when full, 1 = reject the new digit
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | no digits entered, all slots blank
// ST_ENTRY | 0 < count < NUM_DIGITS
// ST_FULL  | count == NUM_DIGITS
// ST_SHOW  | displaying val_digits (or the last value shown after disp_val drops)
module multi_digit_entry #(
    parameter int         NUM_DIGITS = 4,
    parameter logic [3:0] BLANK_CODE = 4'hA,
    parameter int         OVF_MODE   = 0
) (
    input logic                clk,
    input logic                rst,
    multi_digit_entry_if.slave bus
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_DIGITS);
    localparam logic [DW-1:0] BLANK_ALL = {NUM_DIGITS{BLANK_CODE}};

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_SHOW  = 2'd3;

    logic [1:0]    state_q,    state_n;
    logic [DW-1:0] digits_q,   digits_n;
    logic [CW-1:0] count_q,    count_n;
    logic          full_q,     full_n;
    logic          showing_q,  showing_n;
    logic          overflow_q, overflow_n;
    logic          invalid_q,  invalid_n;
    logic          dc_prev_q;
    logic          bs_prev_q;

    logic dc_edge;
    logic bs_edge;

    assign dc_edge = bus.digit_changed & ~dc_prev_q;
    assign bs_edge = bus.backspace & ~bs_prev_q;

    always_comb begin
        state_n    = state_q;
        digits_n   = digits_q;
        count_n    = count_q;
        overflow_n = 1'b0;
        invalid_n  = 1'b0;

        if (bus.clear) begin
            state_n  = ST_EMPTY;
            digits_n = BLANK_ALL;
            count_n  = '0;
        end else if (bus.disp_val) begin
            state_n  = ST_SHOW;
            digits_n = bus.val_digits;
        end else if (bs_edge) begin
            // A simultaneous digit edge is dropped here; prev still updates below.
            case (state_q)
                ST_SHOW: begin
                    state_n  = ST_EMPTY;
                    digits_n = BLANK_ALL;
                    count_n  = '0;
                end
                ST_ENTRY, ST_FULL: begin
                    digits_n = {BLANK_CODE, digits_q[DW-1:4]};
                    count_n  = count_q - 1'b1;
                    state_n  = (count_q == CW'(1)) ? ST_EMPTY : ST_ENTRY;
                end
                default: ;
            endcase
        end else if (dc_edge) begin
            if (bus.number_input > 4'd9) begin
                invalid_n = 1'b1;
            end else begin
                case (state_q)
                    ST_SHOW: begin
                        digits_n = {BLANK_ALL[DW-1:4], bus.number_input};
                        count_n  = CW'(1);
                        state_n  = ST_ENTRY;
                    end
                    ST_FULL: begin
                        overflow_n = 1'b1;
                        if (OVF_MODE == 0) begin
                            digits_n = {digits_q[DW-5:0], bus.number_input};
                        end
                    end
                    default: begin
                        digits_n = {digits_q[DW-5:0], bus.number_input};
                        count_n  = count_q + 1'b1;
                        state_n  = (count_q == COUNT_MAX - 1'b1) ? ST_FULL : ST_ENTRY;
                    end
                endcase
            end
        end

        full_n    = (count_n == COUNT_MAX);
        showing_n = (state_n == ST_SHOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            digits_q   <= BLANK_ALL;
            count_q    <= '0;
            full_q     <= 1'b0;
            showing_q  <= 1'b0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            dc_prev_q  <= 1'b0;
            bs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            digits_q   <= digits_n;
            count_q    <= count_n;
            full_q     <= full_n;
            showing_q  <= showing_n;
            overflow_q <= overflow_n;
            invalid_q  <= invalid_n;
            // Edges masked by clear/disp_val are consumed because prev always follows.
            dc_prev_q  <= bus.digit_changed;
            bs_prev_q  <= bus.backspace;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_count = count_q;
    assign bus.full        = full_q;
    assign bus.showing     = showing_q;
    assign bus.overflow    = overflow_q;
    assign bus.invalid     = invalid_q;
endmodule

// File: tb/tb_multi_digit_entry.sv
module tb_multi_digit_entry;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_digit_entry_if #(.NUM_DIGITS(4)) bus_a ();
    multi_digit_entry_if #(.NUM_DIGITS(4)) bus_b ();

    assign bus_b.digit_changed = bus_a.digit_changed;
    assign bus_b.number_input  = bus_a.number_input;
    assign bus_b.backspace     = bus_a.backspace;
    assign bus_b.clear         = bus_a.clear;
    assign bus_b.disp_val      = bus_a.disp_val;
    assign bus_b.val_digits    = bus_a.val_digits;

    multi_digit_entry #(.NUM_DIGITS(4), .BLANK_CODE(4'hA), .OVF_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    multi_digit_entry #(.NUM_DIGITS(4), .BLANK_CODE(4'hA), .OVF_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: list of entered digits, newest first; index 0 = ovf shift, 1 = reject.
    int          q [2][$];
    bit          show [2];
    logic [15:0] show_val [2];
    bit          m_ovf [2];
    bit          m_inv [2];
    logic        p_dc, p_bs;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            show[k] = 0; show_val[k] = 16'h0; m_ovf[k] = 0; m_inv[k] = 0;
        end
        p_dc = 0; p_bs = 0;
    endtask

    task automatic model_step();
        logic dc_e, bs_e;
        dc_e = bus_a.digit_changed & ~p_dc;
        bs_e = bus_a.backspace & ~p_bs;
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = 0; m_inv[k] = 0;
            if (bus_a.clear) begin
                q[k].delete(); show[k] = 0;
            end else if (bus_a.disp_val) begin
                show[k] = 1; show_val[k] = bus_a.val_digits;
            end else if (bs_e) begin
                if (show[k]) begin
                    q[k].delete(); show[k] = 0;
                end else if (q[k].size() > 0) begin
                    void'(q[k].pop_front());
                end
            end else if (dc_e) begin
                if (bus_a.number_input > 9) begin
                    m_inv[k] = 1;
                end else if (show[k]) begin
                    q[k].delete(); q[k].push_front(int'(bus_a.number_input)); show[k] = 0;
                end else if (q[k].size() == 4) begin
                    m_ovf[k] = 1;
                    if (k == 0) begin
                        void'(q[k].pop_back());
                        q[k].push_front(int'(bus_a.number_input));
                    end
                end else begin
                    q[k].push_front(int'(bus_a.number_input));
                end
            end
        end
        p_dc = bus_a.digit_changed;
        p_bs = bus_a.backspace;
    endtask

    function automatic logic [15:0] exp_digits(int k);
        logic [15:0] r;
        if (show[k]) return show_val[k];
        r = 16'hAAAA;
        for (int i = 0; i < q[k].size(); i++) r[4*i +: 4] = 4'(q[k][i]);
        return r;
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".digits"},   0, 32'(bus_a.digits),      32'(exp_digits(0)));
        chk({tag, ".count"},    0, 32'(bus_a.digit_count), 32'(q[0].size()));
        chk({tag, ".full"},     0, 32'(bus_a.full),        32'(q[0].size() == 4));
        chk({tag, ".showing"},  0, 32'(bus_a.showing),     32'(show[0]));
        chk({tag, ".overflow"}, 0, 32'(bus_a.overflow),    32'(m_ovf[0]));
        chk({tag, ".invalid"},  0, 32'(bus_a.invalid),     32'(m_inv[0]));
        chk({tag, ".digits"},   1, 32'(bus_b.digits),      32'(exp_digits(1)));
        chk({tag, ".count"},    1, 32'(bus_b.digit_count), 32'(q[1].size()));
        chk({tag, ".full"},     1, 32'(bus_b.full),        32'(q[1].size() == 4));
        chk({tag, ".showing"},  1, 32'(bus_b.showing),     32'(show[1]));
        chk({tag, ".overflow"}, 1, 32'(bus_b.overflow),    32'(m_ovf[1]));
        chk({tag, ".invalid"},  1, 32'(bus_b.invalid),     32'(m_inv[1]));
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model, check at next negedge.
    task automatic step(logic dc, logic bs, logic clr, logic dv, logic [3:0] num,
                        logic [15:0] val, string tag);
        bus_a.digit_changed = dc;
        bus_a.backspace     = bs;
        bus_a.clear         = clr;
        bus_a.disp_val      = dv;
        bus_a.number_input  = num;
        bus_a.val_digits    = val;
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic enter(logic [3:0] num, string tag);
        step(1, 0, 0, 0, num, 16'h0, tag);
        step(0, 0, 0, 0, num, 16'h0, tag);
    endtask

    initial begin
        bus_a.digit_changed = 0; bus_a.backspace = 0; bus_a.clear = 0;
        bus_a.disp_val = 0; bus_a.number_input = 0; bus_a.val_digits = 16'h0;
        rst = 1;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all("reset");
        chk("reset_const", 0, 32'(bus_a.digits), 32'h0000AAAA);
        rst = 0;

        enter(4'd1, "e1"); enter(4'd2, "e2"); enter(4'd3, "e3");
        chk("e123_digits", 0, 32'(bus_a.digits), 32'h0000A123);
        chk("e123_count",  0, 32'(bus_a.digit_count), 32'd3);
        chk("e123_full",   0, 32'(bus_a.full), 32'd0);

        enter(4'd4, "e4");
        chk("e4_full", 0, 32'(bus_a.full), 32'd1);
        step(1, 0, 0, 0, 4'd5, 16'h0, "e5");
        chk("ovf0_pulse", 0, 32'(bus_a.overflow), 32'd1);
        chk("ovf1_pulse", 1, 32'(bus_b.overflow), 32'd1);
        step(0, 0, 0, 0, 4'd5, 16'h0, "e5b");
        chk("ovf0_digits", 0, 32'(bus_a.digits), 32'h00002345);
        chk("ovf1_digits", 1, 32'(bus_b.digits), 32'h00001234);
        chk("ovf0_once",   0, 32'(bus_a.overflow), 32'd0);

        step(0, 0, 1, 0, 4'd0, 16'h0, "clr");
        step(0, 0, 0, 0, 4'd0, 16'h0, "clr_rel");
        enter(4'd1, "f1"); enter(4'd2, "f2"); enter(4'd3, "f3");
        step(1, 1, 0, 0, 4'd9, 16'h0, "bs_dc");
        step(0, 0, 0, 0, 4'd9, 16'h0, "bs_rel");
        chk("bs_digits", 0, 32'(bus_a.digits), 32'h0000AA12);
        chk("bs_count",  0, 32'(bus_a.digit_count), 32'd2);

        step(0, 0, 0, 1, 4'd0, 16'h0042, "show");
        chk("show_digits",  0, 32'(bus_a.digits), 32'h00000042);
        chk("show_showing", 0, 32'(bus_a.showing), 32'd1);
        step(0, 0, 0, 0, 4'd0, 16'h0042, "show_drop");
        enter(4'd7, "after_show");
        chk("after_show_digits", 0, 32'(bus_a.digits), 32'h0000AAA7);
        chk("after_show_count",  0, 32'(bus_a.digit_count), 32'd1);

        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 4'd5, 16'h0, "hold");
        step(0, 0, 0, 0, 4'd5, 16'h0, "hold_rel");
        chk("hold_count", 0, 32'(bus_a.digit_count), 32'd2);

        step(1, 0, 0, 0, 4'hC, 16'h0, "inv");
        chk("inv_pulse",  0, 32'(bus_a.invalid), 32'd1);
        chk("inv_digits", 0, 32'(bus_a.digits), 32'h0000AA75);
        step(0, 0, 0, 0, 4'hC, 16'h0, "inv_rel");

        step(0, 0, 0, 1, 4'd0, 16'h9876, "show2");
        step(0, 0, 0, 0, 4'd0, 16'h9876, "show2_drop");
        step(0, 1, 0, 0, 4'd0, 16'h0, "bs_in_show");
        step(0, 0, 0, 0, 4'd0, 16'h0, "bs_in_show_rel");
        chk("bs_show_count", 0, 32'(bus_a.digit_count), 32'd0);

        enter(4'd8, "g1"); enter(4'd6, "g2");
        bus_a.digit_changed = 1; bus_a.number_input = 4'd3;
        #2 rst = 1;
        #1;
        chk("async_rst_a", 0, 32'(bus_a.digits), 32'h0000AAAA);
        chk("async_rst_b", 1, 32'(bus_b.digits), 32'h0000AAAA);
        model_reset();
        @(negedge clk);
        rst = 0;
        step(1, 0, 0, 0, 4'd3, 16'h0, "held_thru_rst");
        chk("held_rst_digits", 0, 32'(bus_a.digits), 32'h0000AAA3);
        step(1, 0, 0, 0, 4'd3, 16'h0, "held2");

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 11) == 0),
                 4'($urandom_range(0, 11)),
                 16'($urandom),
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
